// File: rtl/radix_pkg.sv
`default_nettype none
// ============================================================================
// Module      : radix_pkg
// Description : Shared state encoding and constants for the radix convertor.
// Revision    : 1.0 - initial release
// ============================================================================
package radix_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_CONV = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam int MIN_RADIX = 2;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        CONV = ST_CONV,
        DONE = ST_DONE
    } state_t;

endpackage
`default_nettype wire

// File: rtl/radix_mac.sv
`default_nettype none
// ============================================================================
// Module      : radix_mac
// Description : Combinational Horner step acc*radix+digit with overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module radix_mac #(
    parameter int DIGIT_W = 8,
    parameter int RES_W   = 16
) (
    input  logic [RES_W-1:0]   acc_i,
    input  logic [DIGIT_W-1:0] radix_i,
    input  logic [DIGIT_W-1:0] digit_i,
    output logic [RES_W-1:0]   res_o,
    output logic               ovf_o
);

    // Double-width intermediate cannot itself overflow: (2^W-1)^2 + 2^W-1 < 2^2W.
    logic [2*RES_W-1:0] full_d;

    assign full_d = ((2*RES_W)'(acc_i) * (2*RES_W)'(radix_i)) + (2*RES_W)'(digit_i);
    assign res_o  = full_d[RES_W-1:0];
    assign ovf_o  = |full_d[2*RES_W-1:RES_W];

endmodule
`default_nettype wire

// File: rtl/radix_convertor_param.sv
`default_nettype none
// ============================================================================
// Module      : radix_convertor_param
// Description : Collects NDIG digits of a run-time radix and converts to binary.
// Revision    : 1.0 - initial release
// ============================================================================
module radix_convertor_param
    import radix_pkg::*;
#(
    parameter int DIGIT_W = 8,
    parameter int NDIG    = 4,
    parameter int RES_W   = 16
) (
    input  logic               Clk,
    input  logic               Rst_n,
    input  logic               Start,
    input  logic [DIGIT_W-1:0] Radix,
    input  logic [DIGIT_W-1:0] X,
    input  logic               XValid,
    output logic               XReady,
    output logic [RES_W-1:0]   R,
    output logic               Ack,
    output logic               Err,
    output logic               Ovf,
    output logic               Busy
);

    localparam int IDX_W = $clog2(NDIG);

    state_t             state_q;
    logic [IDX_W-1:0]   cnt_q;
    logic [DIGIT_W-1:0] sir_q [NDIG];
    logic [DIGIT_W-1:0] radix_q;
    logic [RES_W-1:0]   acc_q;
    logic               err_sticky_q;
    logic               ovf_sticky_q;
    logic [RES_W-1:0]   r_q;
    logic               ack_q;
    logic               err_q;
    logic               ovf_q;

    logic [RES_W-1:0]   acc_d;
    logic               mac_ovf;

    radix_mac #(
        .DIGIT_W (DIGIT_W),
        .RES_W   (RES_W)
    ) u_mac (
        .acc_i   (acc_q),
        .radix_i (radix_q),
        .digit_i (sir_q[cnt_q]),
        .res_o   (acc_d),
        .ovf_o   (mac_ovf)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            radix_q      <= '0;
            acc_q        <= '0;
            err_sticky_q <= 1'b0;
            ovf_sticky_q <= 1'b0;
            r_q          <= '0;
            ack_q        <= 1'b0;
            err_q        <= 1'b0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < NDIG; i++) begin
                sir_q[i] <= '0;
            end
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            ovf_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        radix_q      <= Radix;
                        cnt_q        <= '0;
                        acc_q        <= '0;
                        ovf_sticky_q <= 1'b0;
                        err_sticky_q <= (Radix < DIGIT_W'(MIN_RADIX));
                        state_q      <= (Radix < DIGIT_W'(MIN_RADIX)) ? DONE : LOAD;
                    end
                end
                LOAD: begin
                    if (XValid) begin
                        sir_q[cnt_q] <= X;
                        if (X >= radix_q) begin
                            err_sticky_q <= 1'b1;
                        end
                        // Last digit: reuse the counter as the Horner index, MSD first.
                        if (cnt_q == IDX_W'(NDIG - 1)) begin
                            state_q <= CONV;
                        end else begin
                            cnt_q <= cnt_q + IDX_W'(1);
                        end
                    end
                end
                CONV: begin
                    acc_q        <= acc_d;
                    ovf_sticky_q <= ovf_sticky_q | mac_ovf;
                    if (cnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q - IDX_W'(1);
                    end
                end
                DONE: begin
                    r_q     <= err_sticky_q ? '0 : acc_q;
                    err_q   <= err_sticky_q;
                    ovf_q   <= ovf_sticky_q & ~err_sticky_q;
                    ack_q   <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign XReady = (state_q == LOAD);
    assign Busy   = (state_q != IDLE);
    assign R      = r_q;
    assign Ack    = ack_q;
    assign Err    = err_q;
    assign Ovf    = ovf_q;

endmodule
`default_nettype wire
